vm_change_dispenser: RTL and testbench

- Sequences the physical coin hopper when the vending machine returns change.
- Accepts a return amount in won and ejects coins one at a time, using a greedy 1000/500/100 selection over a finite coin inventory.
- Handshakes each coin with the hopper and reports completion, shortfall or hopper fault.
- Sits between the vending-machine core (amount source) and the hopper actuator.

---
 rtl/vm_change_dispenser_pkg.sv | 27 ++
 rtl/vm_coin_inventory.sv | 39 +++
 rtl/vm_change_dispenser.sv | 166 ++++++++++++++++
 tb/tb_vm_change_dispenser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_change_dispenser_pkg.sv
// Shared coin definitions and FSM encoding for the change dispenser.
// TOTAL_BITS_DEF matches the vending-machine core's amount width.
package vm_change_dispenser_pkg;

  localparam int TOTAL_BITS_DEF = 31;
  localparam int COIN_NUM       = 3;

  localparam int COIN_IDX_100  = 0;
  localparam int COIN_IDX_500  = 1;
  localparam int COIN_IDX_1000 = 2;

  localparam logic [COIN_NUM-1:0] SEL_100  = 3'b001;
  localparam logic [COIN_NUM-1:0] SEL_500  = 3'b010;
  localparam logic [COIN_NUM-1:0] SEL_1000 = 3'b100;

  localparam int unsigned VAL_100  = 100;
  localparam int unsigned VAL_500  = 500;
  localparam int unsigned VAL_1000 = 1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/vm_coin_inventory.sv
// Three saturating up/down coin counters; inc and dec of the same type
// in one cycle cancel out.
module vm_coin_inventory
  import vm_change_dispenser_pkg::*;
#(
  parameter int CNT_BITS   = 8,
  parameter int INIT_COUNT = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [COIN_NUM-1:0]                inc,
  input  logic [COIN_NUM-1:0]                dec,
  output logic [COIN_NUM-1:0][CNT_BITS-1:0]  count,
  output logic [COIN_NUM-1:0]                empty
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT_COUNT);

  always_ff @(posedge clk) begin
    for (int i = 0; i < COIN_NUM; i++) begin
      if (!reset_n) begin
        count[i] <= CNT_INIT;
      end else if (inc[i] && !dec[i] && count[i] != CNT_MAX) begin
        count[i] <= count[i] + 1'b1;
      end else if (dec[i] && !inc[i] && count[i] != '0) begin
        count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    empty = '0;
    for (int i = 0; i < COIN_NUM; i++) begin
      empty[i] = (count[i] == '0);
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Greedy 1000/500/100 change dispenser driving a coin hopper one coin at a
// time. Handshake: o_coin_valid rises with a stable o_coin_sel and stays up
// until i_coin_ack is sampled high (or the ack timer expires); a request is
// taken on any edge with i_req_valid & o_req_ready.
module vm_change_dispenser
  import vm_change_dispenser_pkg::*;
#(
  parameter int TOTAL_BITS  = TOTAL_BITS_DEF,
  parameter int CNT_BITS    = 8,
  parameter int INIT_COUNT  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [TOTAL_BITS-1:0] i_req_amount,
  input  logic [COIN_NUM-1:0]   i_refill_coin,
  output logic                  o_coin_valid,
  output logic [COIN_NUM-1:0]   o_coin_sel,
  input  logic                  i_coin_ack,
  output logic                  o_done,
  output logic                  o_short,
  output logic [TOTAL_BITS-1:0] o_short_amount,
  output logic                  o_fault,
  output logic [COIN_NUM-1:0]   o_empty
);

  localparam int TIMER_BITS = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_LIMIT = TIMER_BITS'(ACK_TIMEOUT);
  localparam logic [TOTAL_BITS-1:0] V100  = TOTAL_BITS'(VAL_100);
  localparam logic [TOTAL_BITS-1:0] V500  = TOTAL_BITS'(VAL_500);
  localparam logic [TOTAL_BITS-1:0] V1000 = TOTAL_BITS'(VAL_1000);

  state_t                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   remaining_q, remaining_d;
  logic [COIN_NUM-1:0]     sel_q, sel_d;
  logic                    short_q, short_d;
  logic [TOTAL_BITS-1:0]   short_amt_q, short_amt_d;
  logic [TIMER_BITS-1:0]   timer_q, timer_d;
  logic                    fault_q, fault_d;

  logic [COIN_NUM-1:0]                inv_dec;
  logic [COIN_NUM-1:0][CNT_BITS-1:0]  inv_count;
  logic [COIN_NUM-1:0]                inv_empty;
  logic [COIN_NUM-1:0]                pick_sel;
  logic [TOTAL_BITS-1:0]              sel_value;

  vm_coin_inventory #(
    .CNT_BITS   (CNT_BITS),
    .INIT_COUNT (INIT_COUNT)
  ) u_inv (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (i_refill_coin),
    .dec     (inv_dec),
    .count   (inv_count),
    .empty   (inv_empty)
  );

  // Largest coin that fits the remainder and is in stock.
  always_comb begin
    pick_sel = '0;
    if (remaining_q >= V1000 && !inv_empty[COIN_IDX_1000]) begin
      pick_sel = SEL_1000;
    end else if (remaining_q >= V500 && !inv_empty[COIN_IDX_500]) begin
      pick_sel = SEL_500;
    end else if (remaining_q >= V100 && !inv_empty[COIN_IDX_100]) begin
      pick_sel = SEL_100;
    end
  end

  always_comb begin
    sel_value = '0;
    case (sel_q)
      SEL_100:  sel_value = V100;
      SEL_500:  sel_value = V500;
      SEL_1000: sel_value = V1000;
      default:  sel_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      sel_q       <= '0;
      short_q     <= 1'b0;
      short_amt_q <= '0;
      timer_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      short_q     <= short_d;
      short_amt_q <= short_amt_d;
      timer_q     <= timer_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sel_d       = sel_q;
    short_d     = short_q;
    short_amt_d = short_amt_q;
    timer_d     = timer_q;
    fault_d     = fault_q;
    inv_dec     = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          remaining_d = i_req_amount;
          short_d     = 1'b0;
          short_amt_d = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        timer_d = '0;
        if (pick_sel != '0) begin
          sel_d   = pick_sel;
          state_d = ST_DISPENSE;
        end else begin
          sel_d       = '0;
          short_d     = (remaining_q != '0);
          short_amt_d = remaining_q;
          state_d     = ST_DONE;
        end
      end
      ST_DISPENSE: begin
        // An ack on the last timer cycle still counts as a paid coin.
        if (i_coin_ack) begin
          inv_dec     = sel_q;
          remaining_d = remaining_q - sel_value;
          state_d     = ST_SELECT;
        end else if (timer_q == TIMER_LIMIT) begin
          fault_d     = 1'b1;
          short_d     = 1'b1;
          short_amt_d = remaining_q;
          state_d     = ST_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_req_ready    = (state_q == ST_IDLE);
  assign o_coin_valid   = (state_q == ST_DISPENSE);
  assign o_coin_sel     = (state_q == ST_DISPENSE) ? sel_q : '0;
  assign o_done         = (state_q == ST_DONE);
  assign o_short        = (state_q == ST_DONE) && short_q;
  assign o_short_amount = ((state_q == ST_DONE) && short_q) ? short_amt_q : '0;
  assign o_fault        = fault_q;
  assign o_empty        = inv_empty;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: greedy coin order, shortfall,
// delayed ack, timeout fault, refill/ack collision and mid-dispense reset.
module tb_vm_change_dispenser;

  localparam int TB_TOTAL = 31;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                i_req_valid = 1'b0;
  logic                o_req_ready;
  logic [TB_TOTAL-1:0] i_req_amount = '0;
  logic [2:0]          i_refill_coin = 3'b000;
  logic                o_coin_valid;
  logic [2:0]          o_coin_sel;
  logic                i_coin_ack = 1'b0;
  logic                o_done;
  logic                o_short;
  logic [TB_TOTAL-1:0] o_short_amount;
  logic                o_fault;
  logic [2:0]          o_empty;

  vm_change_dispenser #(
    .TOTAL_BITS (TB_TOTAL),
    .CNT_BITS   (8),
    .INIT_COUNT (8),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_amount   (i_req_amount),
    .i_refill_coin  (i_refill_coin),
    .o_coin_valid   (o_coin_valid),
    .o_coin_sel     (o_coin_sel),
    .i_coin_ack     (i_coin_ack),
    .o_done         (o_done),
    .o_short        (o_short),
    .o_short_amount (o_short_amount),
    .o_fault        (o_fault),
    .o_empty        (o_empty)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];

  bit          got_done;
  logic        last_short;
  logic [31:0] last_amt;
  int          first_valid_cyc;
  int          done_cyc;
  int          valid_cycles;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_req_valid = 1'b0;
    i_coin_ack = 1'b0;
    i_refill_coin = 3'b000;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] inv(input int idx);
    return 32'(dut.u_inv.count[idx]);
  endfunction

  // Issues one request and plays the hopper. ack_delay = cycles of valid
  // without ack before the ack cycle. Coins are checked against exp_q.
  task automatic do_req(input string tag, input logic [TB_TOTAL-1:0] amt,
                        input int ack_delay, input bit never_ack, input bit refill_on_ack);
    int waited;
    int cycles;
    logic [2:0] held;
    logic [2:0] want;
    check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_amount = amt;
    tick();
    i_req_valid = 1'b0;
    waited = 0;
    cycles = 0;
    held = 3'b000;
    got_done = 0;
    first_valid_cyc = -1;
    done_cyc = -1;
    valid_cycles = 0;
    while (!got_done && cycles < 200) begin
      i_coin_ack = 1'b0;
      i_refill_coin = 3'b000;
      if (o_coin_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cycles;
        if (waited == 0) begin
          held = o_coin_sel;
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
          check({tag, "_coin"}, 32'(o_coin_sel), 32'(want));
        end else if (o_coin_sel !== held) begin
          check({tag, "_sel_stable"}, 32'(o_coin_sel), 32'(held));
        end
        if (!never_ack && waited == ack_delay) begin
          i_coin_ack = 1'b1;
          if (refill_on_ack) i_refill_coin = held;
          waited = 0;
        end else begin
          waited++;
        end
      end
      if (o_done) begin
        got_done = 1;
        done_cyc = cycles;
        last_short = o_short;
        last_amt = 32'(o_short_amount);
      end
      tick();
      cycles++;
    end
    i_coin_ack = 1'b0;
    i_refill_coin = 3'b000;
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_all_coins"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit saw_done;

    // Reset state
    do_reset();
    check("rst_ready", 32'(o_req_ready), 32'd1);
    check("rst_valid", 32'(o_coin_valid), 32'd0);
    check("rst_sel", 32'(o_coin_sel), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_short", 32'(o_short), 32'd0);
    check("rst_short_amt", 32'(o_short_amount), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);

    // 1700 -> 1000, 500, 100, 100
    exp_q = '{3'b100, 3'b010, 3'b001, 3'b001};
    do_req("r1700", 31'd1700, 0, 0, 0);
    check("r1700_latency", 32'(first_valid_cyc), 32'd1);
    check("r1700_short", 32'(last_short), 32'd0);
    check("r1700_amt", last_amt, 32'd0);
    check("r1700_inv100", inv(0), 32'd6);
    check("r1700_inv500", inv(1), 32'd7);
    check("r1700_inv1000", inv(2), 32'd7);
    check("r1700_ready_after", 32'(o_req_ready), 32'd1);

    // Zero amount: done two cycles after accept
    do_req("r0", 31'd0, 0, 0, 0);
    check("r0_done_cyc", 32'(done_cyc), 32'd1);
    check("r0_short", 32'(last_short), 32'd0);

    // Drain the 1000 coins, then 1500 must come out as three 500s
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp_q = '{3'b100};
      do_req("drain1000", 31'd1000, 0, 0, 0);
    end
    check("drain_empty", 32'(o_empty), 32'b100);
    exp_q = '{3'b010, 3'b010, 3'b010};
    do_req("r1500", 31'd1500, 0, 0, 0);
    check("r1500_short", 32'(last_short), 32'd0);
    check("r1500_empty", 32'(o_empty), 32'b100);
    check("r1500_inv500", inv(1), 32'd5);

    // 350 -> three 100s, short by 50
    exp_q = '{3'b001, 3'b001, 3'b001};
    do_req("r350", 31'd350, 0, 0, 0);
    check("r350_short", 32'(last_short), 32'd1);
    check("r350_amt", last_amt, 32'd50);
    check("r350_inv100", inv(0), 32'd5);

    // 500 with ack delayed 3 cycles: valid held 4 cycles, one decrement
    exp_q = '{3'b010};
    do_req("r500_slow", 31'd500, 3, 0, 0);
    check("r500_valid_cycles", 32'(valid_cycles), 32'd4);
    check("r500_inv500", inv(1), 32'd4);
    check("r500_short", 32'(last_short), 32'd0);

    // Refill of the 100 coin in the same cycle as its ack: count unchanged
    exp_q = '{3'b001};
    do_req("r100_refill", 31'd100, 0, 0, 1);
    check("refill_ack_inv100", inv(0), 32'd5);

    // Hopper never acks: timeout fault, coin not deducted
    exp_q = '{3'b001};
    do_req("r100_tmo", 31'd100, 0, 1, 0);
    n_assert++;
    assert (valid_cycles >= 15 && valid_cycles <= 16) else begin
      n_fail++;
      $error("FAIL tmo_valid_cycles: observed %0d expected 15..16", valid_cycles);
    end
    check("tmo_fault", 32'(o_fault), 32'd1);
    check("tmo_short", 32'(last_short), 32'd1);
    check("tmo_amt", last_amt, 32'd100);
    check("tmo_inv100", inv(0), 32'd5);

    // Idle refill of a 1000 coin, stray ack in IDLE is ignored
    i_refill_coin = 3'b100;
    i_coin_ack = 1'b1;
    tick();
    i_refill_coin = 3'b000;
    i_coin_ack = 1'b0;
    check("refill_inv1000", inv(2), 32'd1);
    check("idle_ack_inv100", inv(0), 32'd5);
    check("refill_empty", 32'(o_empty), 32'b000);

    // A faulted dispenser still serves requests; fault stays sticky
    exp_q = '{3'b100};
    do_req("r1000_faulted", 31'd1000, 0, 0, 0);
    check("faulted_short", 32'(last_short), 32'd0);
    check("faulted_sticky", 32'(o_fault), 32'd1);
    check("faulted_empty", 32'(o_empty), 32'b100);

    // Reset in the middle of DISPENSE
    i_req_valid = 1'b1;
    i_req_amount = 31'd500;
    tick();
    i_req_valid = 1'b0;
    tick();
    check("midrst_pre_valid", 32'(o_coin_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_valid", 32'(o_coin_valid), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_ready", 32'(o_req_ready), 32'd1);
    check("midrst_fault", 32'(o_fault), 32'd0);
    check("midrst_inv1000", inv(2), 32'd8);
    saw_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_done) saw_done = 1;
      tick();
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
